bus_ram_responder: RTL

BUS_RAM_RESPONDER -- requirements
Module: bus_ram_responder

---
 rtl/bus_pkg.sv | 12 +
 rtl/bus_ram_array.sv | 41 ++++
 rtl/bus_ram_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the bus RAM responder slice.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } bus_state_e;

    localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/bus_ram_array.sv
// Word-wide RAM with registered synchronous read and per-byte write enables.
module bus_ram_array #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_mask,
    input  logic [31:0]       wr_data
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data_q;
    logic [31:0] rd_data_d;

    // Read data is held between launches so it survives the wait phase.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
        if (wr_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/bus_ram_responder.sv
// Single-port bus slave: decodes a word window, inserts wait states and
// answers from bus_ram_array with a one-cycle ready strobe.
module bus_ram_responder
    import bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned WAIT_STATES  = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address_in,
    input  logic        read_in,
    input  logic        write_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        ready_out
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [32:0] SPAN   = 33'(DEPTH) * 33'd4;
    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES != 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    bus_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic [3:0]            mask_q, mask_d;
    logic                  in_range_q, in_range_d;

    logic [31:0]       offset;
    logic [ADDR_W-1:0] index;
    logic              in_range;
    logic              req;
    logic              accept;
    logic              wr_en;
    logic [31:0]       rd_data;

    // Addresses below the base wrap to huge offsets and fall out of range.
    assign offset   = address_in - BASE_ADDRESS;
    assign index    = offset[ADDR_W+1:2];
    assign in_range = {1'b0, offset} < SPAN;
    assign req      = read_in | write_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            mask_q     <= '0;
            in_range_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            mask_q     <= mask_d;
            in_range_q <= in_range_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        mask_d     = mask_q;
        in_range_d = in_range_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d      = index;
                    mask_d     = write_mask_in;
                    in_range_d = in_range;
                    cnt_d      = CNT_LOAD;
                    state_d    = (WAIT_STATES != 0) ? WAIT : RESPOND;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A withdrawn request only suppresses ready; assertion always comes from state.
    always_comb begin
        accept         = (state_q == IDLE) && req;
        ready_out      = (state_q == RESPOND) && req;
        wr_en          = (state_q == RESPOND) && write_in && in_range_q;
        read_value_out = '0;
        if (ready_out && in_range_q) begin
            read_value_out = rd_data;
        end
    end

    bus_ram_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rd_en   (accept),
        .rd_addr (index),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (idx_q),
        .wr_mask (mask_q),
        .wr_data (write_value_in)
    );

endmodule
